fp_addsub_arbiter: RTL and testbench

//  Shares one FAddSubFSM-style FP add/sub unit between NREQ requesters.
//  - Round-robin choice among pending requests; one operation in flight at a time.
//  - Registers operands and op select, drives the unit's req/ack handshake, captures the result.
//  - Returns the result with a one-cycle ack to the granted requester.
//  - Sits between the C2 core's FP issue ports and the single shared FP adder instance.

---
 rtl/fp_arb_pkg.sv | 19 +
 rtl/fp_addsub_arbiter_rr_pick.sv | 27 ++
 rtl/fp_addsub_arbiter.sv | 107 ++++++++++
 tb/tb_fp_addsub_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared definitions for the FP add/sub unit arbiter: controller state encoding,
// operand width and a small wrap-around increment helper.
package fp_arb_pkg;

   localparam int FP_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Increment modulo n; used for the round-robin pointer, correct for any n.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/fp_addsub_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping from NREQ-1 back to 0. Shared by the mul/div unit arbiters as well.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int off = 0; off < NREQ; off++) begin
         int pos;
         pos = (int'(ptr) + off) % NREQ;
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = IDW'(pos);
         end
      end
   end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one req/ack FP add/sub unit between NREQ requesters: round-robin grant,
// registered operands to the unit, result capture and a one-cycle ack back.
module fp_addsub_arbiter
   import fp_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      sub,
   input  logic [FP_W*NREQ-1:0] p0,
   input  logic [FP_W*NREQ-1:0] p1,
   output logic [NREQ-1:0]      ack,
   output logic [FP_W-1:0]      out,
   output logic                 busy,
   output logic [IDW-1:0]       gnt_id,
   output logic                 u_req,
   output logic                 u_sub,
   output logic [FP_W-1:0]      u_p0,
   output logic [FP_W-1:0]      u_p1,
   input  logic                 u_ack,
   input  logic [FP_W-1:0]      u_out
);

   state_t          state, state_nxt;
   logic [IDW-1:0]  rr_ptr;
   logic            pick_found;
   logic [IDW-1:0]  pick_idx;
   logic            sel_sub;
   logic [FP_W-1:0] sel_p0, sel_p1;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      sel_sub = 1'b0;
      sel_p0  = '0;
      sel_p1  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == IDW'(i)) begin
            sel_sub = sub[i];
            sel_p0  = p0[FP_W*i +: FP_W];
            sel_p1  = p1[FP_W*i +: FP_W];
         end
      end
   end

   // A u_ack seen in IDLE or DONE falls through untouched: those states ignore it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_found) state_nxt = ISSUE;
         ISSUE:   state_nxt = u_ack ? DONE : WAIT;
         WAIT:    if (u_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ack = '0;
      if (state == DONE) ack[gnt_id] = 1'b1;
      u_req = (state == ISSUE);
      busy  = (state != IDLE);
   end

   // NOTE: state and datapath registers use non-blocking assignments and a
   // synchronous reset so every flop here clears on the same sampled edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         gnt_id <= '0;
         u_sub  <= 1'b0;
         u_p0   <= '0;
         u_p1   <= '0;
         out    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  gnt_id <= pick_idx;
                  u_sub  <= sel_sub;
                  u_p0   <= sel_p0;
                  u_p1   <= sel_p1;
               end
            end
            ISSUE, WAIT: begin
               if (u_ack) out <= u_out;
            end
            DONE:    rr_ptr <= IDW'(wrap_inc(int'(gnt_id), NREQ));
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: table-driven single requests, directed corner
// sequences and randomized multi-requester traffic against a transaction-level model.
module tb_fp_addsub_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req, sub;
   logic [32*NREQ-1:0] p0, p1;
   logic [NREQ-1:0]   ack;
   logic [31:0]       out;
   logic              busy;
   logic [IDW-1:0]    gnt_id;
   logic              u_req, u_sub;
   logic [31:0]       u_p0, u_p1;
   logic              u_ack;
   logic [31:0]       u_out;

   fp_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .sub    (sub),
      .p0     (p0),
      .p1     (p1),
      .ack    (ack),
      .out    (out),
      .busy   (busy),
      .gnt_id (gnt_id),
      .u_req  (u_req),
      .u_sub  (u_sub),
      .u_p0   (u_p0),
      .u_p1   (u_p1),
      .u_ack  (u_ack),
      .u_out  (u_out)
   );

   always #5 clk = ~clk;

   // ---------------- single-precision helpers (normal numbers and zero) ----------------
   function automatic real sp2real(input logic [31:0] b);
      logic [63:0] d;
      int e;
      if (b[30:0] == 31'd0) return 0.0;
      e = int'(b[30:23]) - 127 + 1023;
      d = {b[31], e[10:0], b[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real2sp(input real r);
      logic [63:0] d;
      int e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      return real2sp(s ? sp2real(a) - sp2real(b) : sp2real(a) + sp2real(b));
   endfunction

   function automatic logic [31:0] int2sp(input int n);
      return real2sp(real'(n));
   endfunction

   // ---------------- shared FP unit model: u_ack unit_l cycles after u_req ----------------
   int          unit_l = 3;
   logic        stray  = 1'b0;
   logic        u_pend = 1'b0;
   int          u_cnt  = 0;
   logic [31:0] u_res  = '0;

   always @(posedge clk) begin
      if (u_req === 1'b1 && unit_l > 0) begin
         u_pend <= 1'b1;
         u_cnt  <= unit_l - 1;
         u_res  <= fp_op(u_p0, u_p1, u_sub);
      end else if (u_pend) begin
         if (u_cnt == 0) u_pend <= 1'b0;
         else            u_cnt  <= u_cnt - 1;
      end
   end

   assign u_ack = stray | ((unit_l == 0) ? u_req : (u_pend && u_cnt == 0));
   assign u_out = (unit_l == 0) ? fp_op(u_p0, u_p1, u_sub) : u_res;

   // ---------------- scoreboard and transaction-level reference ----------------
   typedef struct {
      int          due;
      int          idx;
      logic [31:0] res;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [3:0]  ack;
      logic [1:0]  gnt;
      logic [31:0] out;
   } ev_t;

   typedef struct {
      int          idx;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      int          l;
      logic [31:0] res;
   } vec_t;

   exp_t       exp_q[$];
   ev_t        ack_log[$];
   int         ureq_log[$];
   int         cyc = 0;
   int         free_at = 0, bz_lo = 0, bz_hi = 0, m_ptr = 0;
   logic [3:0] ack_s, dropped;
   int         n_vec = 0, n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Grant timing follows the documented latency: decision at c, u_req at c+1,
   // ack at c+2+L, next decision no earlier than c+3+L.
   task automatic model_cycle();
      exp_t e;
      logic eb, eu;
      eb = (cyc >= bz_lo) && (cyc < bz_hi);
      eu = eb && (cyc == bz_lo);
      check("busy_ureq", {62'd0, busy, u_req}, {62'd0, eb, eu});
      if (u_req === 1'b1) ureq_log.push_back(cyc);
      if (ack !== 4'd0) ack_log.push_back('{cyc, ack, gnt_id, out});
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check("ack_onehot", ack, 64'd1 << e.idx);
         check("ack_gnt_id", gnt_id, e.idx);
         check("ack_out", out, e.res);
      end else begin
         check("no_ack", ack, 0);
      end
      if (!reset) begin
         exp_q.delete();
         bz_lo = 0; bz_hi = 0; free_at = cyc + 1; m_ptr = 0;
      end else if (cyc >= free_at && req != 0) begin
         int w;
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            int p;
            p = (m_ptr + k) % NREQ;
            if (w < 0 && req[p]) w = p;
         end
         e.due = cyc + 2 + unit_l;
         e.idx = w;
         e.res = fp_op(p0[32*w +: 32], p1[32*w +: 32], sub[w]);
         exp_q.push_back(e);
         bz_lo = cyc + 1; bz_hi = cyc + 3 + unit_l; free_at = bz_hi;
         m_ptr = (w + 1) % NREQ;
      end
   endtask

   // One clock: sample at negedge, then drive next-cycle inputs 1 time unit after posedge.
   task automatic tick();
      @(negedge clk);
      ack_s = ack;
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
      dropped = req & ack_s;
      req     = req & ~ack_s;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic set_req(input int i, input logic s, input logic [31:0] a, input logic [31:0] b);
      sub[i]         = s;
      p0[32*i +: 32] = a;
      p1[32*i +: 32] = b;
      req[i]         = 1'b1;
   endtask

   task automatic wait_acks(input int n, input int budget);
      int start, k;
      start = ack_log.size();
      k = 0;
      while (ack_log.size() < start + n && k < budget) begin
         tick();
         k++;
      end
      if (ack_log.size() < start + n) check("ack_timeout", ack_log.size(), start + n);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl[6];
      int   t0, n0, u0;
      ev_t  ev;

      tbl[0] = '{2, 1'b0, 32'h3F800000, 32'h40000000, 3, 32'h40400000};
      tbl[1] = '{0, 1'b1, 32'h40A00000, 32'h3F800000, 3, 32'h40800000};
      tbl[2] = '{1, 1'b0, 32'h40400000, 32'h40800000, 0, 32'h40E00000};
      tbl[3] = '{3, 1'b1, 32'h3F800000, 32'h40000000, 1, 32'hBF800000};
      tbl[4] = '{0, 1'b0, 32'h41200000, 32'h41200000, 0, 32'h41A00000};
      tbl[5] = '{2, 1'b1, 32'h40000000, 32'h40000000, 2, 32'h00000000};

      reset = 1'b0; req = '0; sub = '0; p0 = '0; p1 = '0; stray = 1'b0; unit_l = 3;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack",    ack,    0);
      check("rst_busy",   busy,   0);
      check("rst_out",    out,    0);
      check("rst_gnt_id", gnt_id, 0);
      check("rst_u_req",  u_req,  0);
      check("rst_u_ops",  {u_sub, u_p0, u_p1}, 0);
      reset = 1'b1;
      cyc = 0; free_at = 0; bz_lo = 0; bz_hi = 0; m_ptr = 0;

      // Single-requester vectors, including L=0 (u_ack in the ISSUE cycle).
      for (int v = 0; v < 6; v++) begin
         unit_l = tbl[v].l;
         set_req(tbl[v].idx, tbl[v].s, tbl[v].a, tbl[v].b);
         t0 = cyc; n0 = ack_log.size(); u0 = ureq_log.size();
         wait_acks(1, 20);
         if (ack_log.size() > n0) begin
            ev = ack_log[n0];
            check("tbl_latency", ev.cyc - t0, 2 + tbl[v].l);
            check("tbl_ack", ev.ack, 64'd1 << tbl[v].idx);
            check("tbl_out", ev.out, tbl[v].res);
         end
         if (ureq_log.size() > u0) check("tbl_ureq_cycle", ureq_log[u0] - t0, 1);
         check("tbl_busy_after", busy, 0);
         idle(2);
      end

      // All four requesting from a fresh pointer: served 0,1,2,3, six cycles apart.
      do_reset();
      unit_l = 3;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'(i % 2), int2sp(i + 1), int2sp(2));
      n0 = ack_log.size();
      wait_acks(4, 60);
      if (ack_log.size() >= n0 + 4) begin
         for (int k = 0; k < 4; k++) begin
            check("rr_order", ack_log[n0+k].ack, 64'd1 << k);
            check("rr_gnt_id", ack_log[n0+k].gnt, k);
            if (k > 0) check("rr_spacing", ack_log[n0+k].cyc - ack_log[n0+k-1].cyc, 6);
         end
      end
      idle(2);

      // Requester 3 served, then 0 and 3 together: pointer has wrapped to 0.
      set_req(3, 1'b0, int2sp(7), int2sp(8));
      wait_acks(1, 20);
      set_req(0, 1'b0, int2sp(1), int2sp(1));
      set_req(3, 1'b1, int2sp(9), int2sp(4));
      n0 = ack_log.size();
      wait_acks(2, 30);
      if (ack_log.size() >= n0 + 2) begin
         check("wrap_first",  ack_log[n0].ack,   4'b0001);
         check("wrap_second", ack_log[n0+1].ack, 4'b1000);
         check("wrap_out",    ack_log[n0+1].out, int2sp(5));
      end
      idle(2);

      // Reset in WAIT, unit answers the following cycle into IDLE.
      unit_l = 3;
      set_req(1, 1'b0, int2sp(5), int2sp(6));
      t0 = cyc; n0 = ack_log.size();
      idle(3);
      check("wait_busy", busy, 1);
      reset = 1'b0;
      req   = '0;
      tick();
      reset = 1'b1;
      check("mid_rst_stray_uack", u_ack,  1);
      check("mid_rst_busy",       busy,   0);
      check("mid_rst_out",        out,    0);
      check("mid_rst_gnt_id",     gnt_id, 0);
      check("mid_rst_u_ops",      {u_sub, u_p0, u_p1}, 0);
      idle(6);
      check("mid_rst_no_ack", ack_log.size(), n0);

      // Stray u_ack with nothing pending.
      stray = 1'b1;
      tick();
      stray = 1'b0;
      idle(4);

      // Operands disturbed during WAIT must not reach the unit.
      unit_l = 3;
      set_req(0, 1'b1, 32'h40A00000, 32'h3F800000);
      n0 = ack_log.size();
      idle(2);
      p0[31:0] = 32'h12345678;
      p1[31:0] = 32'h7F000000;
      tick();
      check("hold_u_p0", u_p0, 32'h40A00000);
      check("hold_u_p1", u_p1, 32'h3F800000);
      check("hold_u_sub", u_sub, 1);
      wait_acks(1, 20);
      if (ack_log.size() > n0) check("hold_out", ack_log[n0].out, 32'h40800000);
      idle(2);

      // Randomized traffic across several unit latencies.
      for (int ph = 0; ph < 4; ph++) begin
         unit_l = (ph == 0) ? 2 : (ph == 1) ? 0 : (ph == 2) ? 3 : 1;
         for (int n = 0; n < 250; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
               if (!req[i] && !dropped[i] && $urandom_range(0, 2) == 0)
                  set_req(i, 1'($urandom_range(0, 1)),
                          int2sp(int'($urandom_range(1, 1000))),
                          int2sp(int'($urandom_range(1, 1000))));
            end
         end
         for (int k = 0; k < 100 && req != 0; k++) tick();
         idle(4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
